// File: rtl/wb_slv_bridge.sv
// wb_slv_bridge: Wishbone classic slave to simple localbus bridge.
// A Wishbone request is latched in IDLE. The bridge then issues a one-cycle
// wr_out or rd_out strobe and waits for ack_in. After that it gives a
// one-cycle ack_o (or err_o) termination.
// Optional feature: define WB_SLV_BRIDGE_TIMEOUT_EN to add a WAIT timeout
// that terminates with err_o after TO_CYC cycles without ack_in.
module wb_slv_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [31:0]         adr_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                wr_out,
    output logic                rd_out,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [DATA_W-1:0]   data_out,
    output logic [DATA_W/8-1:0] be_out,
    input  logic                ack_in,
    input  logic [DATA_W-1:0]   data_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Value the WAIT counter holds during the last permitted WAIT cycle.
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

    logic [1:0]          r_state;
    logic                r_we;
    logic                r_ack;
    logic                r_err;
    logic                r_wr;
    logic                r_rd;
    logic [DATA_W-1:0]   r_dat_o;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_be;

    logic [1:0] w_state_nxt;
    logic       w_ack_nxt;
    logic       w_err_nxt;
    logic       w_wr_nxt;
    logic       w_rd_nxt;
    logic       w_lat;
    logic       w_cap;
    logic       w_oor;
    logic       w_to_hit;

    // Any address bit above the localbus window makes the request illegal.
    assign w_oor = |adr_i[31:ADDR_W];

`ifdef WB_SLV_BRIDGE_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Timeout counter: cleared on WAIT entry, counts WAIT cycles without ack_in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= 16'd0;
        end else if (w_lat && !w_oor) begin
            r_to_cnt <= 16'd0;
        end else if ((r_state == ST_WAIT) && !ack_in) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    assign w_to_hit = (r_to_cnt == TO_LAST);
`else
    // No timeout: TO_CYC is irrelevant, so the term is always false.
    assign w_to_hit = 1'b0 & (TO_LAST == 16'd0);
`endif

    // Next-state and next-output decode for the request/wait/response sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
        w_lat       = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    w_lat = 1'b1;
                    if (w_oor) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_wr_nxt    = we_i;
                        w_rd_nxt    = !we_i;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Master abandoning the cycle wins over a coincident ack_in.
                if (!cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (ack_in) begin
                    w_state_nxt = ST_RESP;
                    w_ack_nxt   = 1'b1;
                    w_cap       = !r_we;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_RESP;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and termination/strobe pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    // Request latch: address, write data, byte enables and direction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr <= '0;
            r_data <= '0;
            r_be   <= '0;
            r_we   <= 1'b0;
        end else if (w_lat) begin
            r_addr <= adr_i[ADDR_W-1:0];
            r_data <= dat_i;
            r_be   <= sel_i;
            r_we   <= we_i;
        end else begin
            r_addr <= r_addr;
            r_data <= r_data;
            r_be   <= r_be;
            r_we   <= r_we;
        end
    end

    // Read data capture; holds across writes, errors and aborts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dat_o <= '0;
        end else if (w_cap) begin
            r_dat_o <= data_in;
        end else begin
            r_dat_o <= r_dat_o;
        end
    end

    assign dat_o    = r_dat_o;
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign wr_out   = r_wr;
    assign rd_out   = r_rd;
    assign addr_out = r_addr;
    assign data_out = r_data;
    assign be_out   = r_be;

endmodule

// File: doc/wb_slv_bridge.md
WB_SLV_BRIDGE -- requirements
Module: wb_slv_bridge

Interface
REQ-001 Parameter ADDR_W, default 8: localbus byte-address width, range 2..16.
REQ-002 Parameter DATA_W, default 32: data width, one of 8/16/32/64.
REQ-003 Parameter TO_CYC, default 255: timeout limit in clk_i cycles, range 1..65535; used only with timeout compiled in.
REQ-004 clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 cyc_i, stb_i, we_i  in  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-007 adr_i  in  32  Wishbone byte address.
REQ-008 sel_i  in  DATA_W/8  byte selects.
REQ-009 dat_i  in  DATA_W  write data.
REQ-010 dat_o  out  DATA_W  registered read data.
REQ-011 ack_o, err_o  out  1 each  one-cycle termination pulses.
REQ-012 wr_out, rd_out  out  1 each  one-cycle localbus strobes.
REQ-013 addr_out  out  ADDR_W  latched byte address; data_out  out  DATA_W  latched write data; be_out  out  DATA_W/8  latched byte enables.
REQ-014 ack_in  in  1  localbus completion; data_in  in  DATA_W  read data, valid while ack_in is high.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; state is registered.
REQ-016 IDLE: cyc_i&&stb_i at edge N latches adr_i[ADDR_W-1:0], dat_i, sel_i and we_i; moves to WAIT, or to RESP with error if any of adr_i[31:ADDR_W] is nonzero.
REQ-017 On a legal request, wr_out (we_i=1) or rd_out (we_i=0) is high for exactly cycle N+1, the first WAIT cycle; it is never high in any other cycle.
REQ-018 Out-of-range request: no localbus strobe; err_o high in cycle N+1; ack_o stays low.
REQ-019 WAIT: ack_in is sampled every WAIT cycle, including the strobe cycle; on ack_in the next state is RESP, and for reads data_in is captured into dat_o on the same edge.
REQ-020 RESP lasts exactly one cycle with ack_o=1 (or err_o=1), then returns to IDLE; ack_o and err_o are never high together.
REQ-021 Minimum latency: request at edge N, ack_in in cycle N+1, ack_o in cycle N+2; back-to-back requests are accepted from the IDLE cycle after RESP, one transaction per 3 cycles minimum.
REQ-022 cyc_i low in WAIT: abort to IDLE with no ack_o/err_o; an already-issued strobe is not retracted; a later ack_in is ignored and dat_o is unchanged.
REQ-023 ack_in outside WAIT is ignored.
REQ-024 dat_o holds the last captured read data; it does not change on writes, errors or aborts.
REQ-025 addr_out, data_out and be_out hold their values from the request latch until the next accepted request.

Reset
REQ-026 rst_n_i low immediately forces: state IDLE; ack_o, err_o, wr_out, rd_out = 0; dat_o, addr_out, data_out, be_out = 0; timeout counter = 0.
REQ-027 Reset asserted mid-transaction abandons it with no termination; the first request is accepted on the first edge with rst_n_i high.

Configuration
REQ-028 Macro WB_SLV_BRIDGE_TIMEOUT_EN defined: a 16-bit counter clears on WAIT entry and increments each WAIT cycle without ack_in.
REQ-029 With the macro, if the counter reaches TO_CYC with no ack_in, the next state is RESP with err_o=1 and dat_o unchanged; ack_in in that same cycle takes priority and gives ack_o.
REQ-030 Without the macro there is no counter: WAIT persists until ack_in or cyc_i low, and err_o comes only from REQ-018.

Verification
REQ-031 Write adr_i=0x10, dat_i=0xDEADBEEF, sel_i=0xF; ack_in in the first WAIT cycle -> wr_out one cycle, addr_out=0x10, data_out=0xDEADBEEF, be_out=0xF, ack_o at N+2.
REQ-032 Read adr_i=0x24; ack_in 3 cycles after rd_out with data_in=0x12345678 -> dat_o=0x12345678, ack_o one cycle later, single ack_o pulse.
REQ-033 Read adr_i=0x100 with ADDR_W=8 -> no rd_out, err_o in cycle N+1, dat_o unchanged.
REQ-034 Macro on, TO_CYC=4, no ack_in -> err_o after 4 WAIT cycles; repeat with ack_in in the 4th WAIT cycle -> ack_o, no err_o.
REQ-035 Drop cyc_i in the 2nd WAIT cycle, then pulse ack_in -> no ack_o/err_o, IDLE; the next request completes normally.
REQ-036 Assert rst_n_i low during WAIT -> all outputs 0 asynchronously; after release, a write completes in 2 cycles.
